// File: rtl/cipher_stream_ctrl.sv
// cipher_stream_ctrl
// Streaming I/O controller wrapped around a toy authenticated-cipher datapath.
// It runs key/nonce initialisation, absorbs associated data, encrypts or
// decrypts payload blocks, and then produces the tag. In decrypt mode it also
// checks the tag. Payload results go out through a single registered stage
// that can sit under backpressure.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   key_i, nonce_i          key / nonce, latched when a start is accepted
//   decrypt_i               0 = encrypt, 1 = decrypt, latched on start
//   ad_len_i, data_len_i    AD / payload block counts, latched on start
//   tag_i                   expected tag, sampled in TAG (decrypt only)
//   start_i                 start request, honoured only in IDLE
//   busy_o, finish_o        operation in progress / one-cycle completion pulse
//   indata_*                upstream valid/ready stream (AD and payload)
//   outdata_*               downstream valid/ready stream (payload results)
//   tag_o, tag_valid_o      computed tag and its valid flag
//   auth_fail_o             decrypt-mode tag mismatch
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start_i
// INIT      | ROUNDS permutation cycles on key ^ nonce
// AD_WAIT   | waiting to accept one AD block
// AD_PERM   | ROUNDS permutation cycles after absorbing an AD block
// DATA_WAIT | waiting to accept one payload block (output register empty)
// DATA_PERM | ROUNDS permutation cycles; the output register drains meanwhile
// TAG       | waits for the output register to drain, then registers the tag
// DONE      | finish pulse, then back to IDLE

module cipher_stream_ctrl #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 8,
  parameter int ROUNDS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] key_i,
  input  logic [DATA_W-1:0] nonce_i,
  input  logic              decrypt_i,
  input  logic [LEN_W-1:0]  ad_len_i,
  input  logic [LEN_W-1:0]  data_len_i,
  input  logic [DATA_W-1:0] tag_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              finish_o,
  input  logic [DATA_W-1:0] indata_i,
  input  logic              indata_valid_i,
  output logic              indata_ready_o,
  output logic [DATA_W-1:0] outdata_o,
  output logic              outdata_valid_o,
  input  logic              outdata_ready_i,
  output logic [DATA_W-1:0] tag_o,
  output logic              tag_valid_o,
  output logic              auth_fail_o
);

  localparam int RND_W = $clog2(ROUNDS + 1);
  localparam logic [RND_W-1:0] RND_LOAD = RND_W'(ROUNDS);
  localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_AD_WAIT,
    S_AD_PERM,
    S_DATA_WAIT,
    S_DATA_PERM,
    S_TAG,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] s_q;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] tag_q;
  logic              decrypt_q;
  logic [LEN_W-1:0]  ad_cnt;
  logic [LEN_W-1:0]  data_cnt;
  logic [RND_W-1:0]  rnd_cnt;
  logic              out_valid_q;
  logic              tag_valid_q;
  logic              auth_fail_q;

  logic              accept;
  logic              rnd_last;
  logic [DATA_W-1:0] out_blk;
  logic [DATA_W-1:0] absorb_blk;
  logic [DATA_W-1:0] tag_calc;

  // One permutation round: rotate left by one, then mix in the key.
  function automatic logic [DATA_W-1:0] p_round(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] k);
    return {x[DATA_W-2:0], x[DATA_W-1]} ^ k;
  endfunction

  assign rnd_last   = (rnd_cnt == RND_ONE);
  assign out_blk    = indata_i ^ s_q;
  // Decrypt absorbs the recovered plaintext, so both directions evolve S
  // identically for a matching plaintext.
  assign absorb_blk = (state == S_DATA_WAIT && decrypt_q) ? out_blk : indata_i;
  assign tag_calc   = s_q ^ key_q;
  assign accept     = indata_ready_o && indata_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    busy_o         = 1'b1;
    finish_o       = 1'b0;
    indata_ready_o = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = S_INIT;
      end
      S_INIT, S_AD_PERM: begin
        if (rnd_last) begin
          if (ad_cnt != '0)        state_nxt = S_AD_WAIT;
          else if (data_cnt != '0) state_nxt = S_DATA_WAIT;
          else                     state_nxt = S_TAG;
        end
      end
      S_AD_WAIT: begin
        indata_ready_o = !out_valid_q;
        if (indata_valid_i && !out_valid_q) state_nxt = S_AD_PERM;
      end
      S_DATA_WAIT: begin
        indata_ready_o = !out_valid_q;
        if (indata_valid_i && !out_valid_q) state_nxt = S_DATA_PERM;
      end
      S_DATA_PERM: begin
        if (rnd_last) begin
          if (data_cnt != '0) state_nxt = S_DATA_WAIT;
          else                state_nxt = S_TAG;
        end
      end
      S_TAG: begin
        if (!out_valid_q) state_nxt = S_DONE;
      end
      S_DONE: begin
        finish_o  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q       <= '0;
      s_q         <= '0;
      out_q       <= '0;
      tag_q       <= '0;
      decrypt_q   <= 1'b0;
      ad_cnt      <= '0;
      data_cnt    <= '0;
      rnd_cnt     <= '0;
      out_valid_q <= 1'b0;
      tag_valid_q <= 1'b0;
      auth_fail_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            key_q       <= key_i;
            decrypt_q   <= decrypt_i;
            ad_cnt      <= ad_len_i;
            data_cnt    <= data_len_i;
            s_q         <= key_i ^ nonce_i;
            rnd_cnt     <= RND_LOAD;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            auth_fail_q <= 1'b0;
          end
        end
        S_INIT, S_AD_PERM, S_DATA_PERM: begin
          s_q     <= p_round(s_q, key_q);
          rnd_cnt <= rnd_cnt - 1'b1;
        end
        S_AD_WAIT: begin
          if (accept) begin
            s_q     <= s_q ^ indata_i;
            ad_cnt  <= ad_cnt - 1'b1;
            rnd_cnt <= RND_LOAD;
          end
        end
        S_DATA_WAIT: begin
          if (accept) begin
            s_q         <= s_q ^ absorb_blk;
            data_cnt    <= data_cnt - 1'b1;
            rnd_cnt     <= RND_LOAD;
            out_q       <= out_blk;
            out_valid_q <= 1'b1;
          end
        end
        S_TAG: begin
          if (!out_valid_q) begin
            tag_q       <= tag_calc;
            tag_valid_q <= 1'b1;
            auth_fail_q <= decrypt_q && (tag_calc != tag_i);
          end
        end
        default: ;
      endcase

      // A load needs an empty register, so a drain never coincides with one.
      if (out_valid_q && outdata_ready_i) begin
        out_valid_q <= 1'b0;
        out_q       <= '0;
      end
    end
  end

  assign outdata_o       = out_q;
  assign outdata_valid_o = out_valid_q;
  assign tag_o           = tag_q;
  assign tag_valid_o     = tag_valid_q;
  assign auth_fail_o     = auth_fail_q;

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
module tb_cipher_stream_ctrl;

  localparam int W  = 128;
  localparam int R  = 4;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- small instance: DATA_W=8, ROUNDS=1 ----------------
  logic [SW-1:0] s_key = '0, s_nonce = '0, s_tag_in = '0, s_indata = '0;
  logic [SW-1:0] s_outdata, s_tag;
  logic [7:0]    s_ad_len = '0, s_data_len = '0;
  logic s_dec = 1'b0, s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic s_busy, s_finish, s_in_ready, s_out_valid, s_tag_valid, s_auth_fail;

  cipher_stream_ctrl #(.DATA_W(SW), .LEN_W(8), .ROUNDS(1)) u_small (
    .clk_i(clk), .rst_i(rst), .key_i(s_key), .nonce_i(s_nonce),
    .decrypt_i(s_dec), .ad_len_i(s_ad_len), .data_len_i(s_data_len),
    .tag_i(s_tag_in), .start_i(s_start), .busy_o(s_busy), .finish_o(s_finish),
    .indata_i(s_indata), .indata_valid_i(s_in_valid), .indata_ready_o(s_in_ready),
    .outdata_o(s_outdata), .outdata_valid_o(s_out_valid),
    .outdata_ready_i(s_out_ready), .tag_o(s_tag), .tag_valid_o(s_tag_valid),
    .auth_fail_o(s_auth_fail)
  );

  // ---------------- big instance: DATA_W=128, ROUNDS=4 ----------------
  logic [W-1:0] b_key = '0, b_nonce = '0, b_tag_in = '0, b_indata = '0;
  logic [W-1:0] b_outdata, b_tag;
  logic [7:0]   b_ad_len = '0, b_data_len = '0;
  logic b_dec = 1'b0, b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic b_busy, b_finish, b_in_ready, b_out_valid, b_tag_valid, b_auth_fail;

  cipher_stream_ctrl #(.DATA_W(W), .LEN_W(8), .ROUNDS(R)) u_big (
    .clk_i(clk), .rst_i(rst), .key_i(b_key), .nonce_i(b_nonce),
    .decrypt_i(b_dec), .ad_len_i(b_ad_len), .data_len_i(b_data_len),
    .tag_i(b_tag_in), .start_i(b_start), .busy_o(b_busy), .finish_o(b_finish),
    .indata_i(b_indata), .indata_valid_i(b_in_valid), .indata_ready_o(b_in_ready),
    .outdata_o(b_outdata), .outdata_valid_o(b_out_valid),
    .outdata_ready_i(b_out_ready), .tag_o(b_tag), .tag_valid_o(b_tag_valid),
    .auth_fail_o(b_auth_fail)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- table vectors for the small instance ----------------
  typedef struct {
    bit            dec;
    logic [SW-1:0] key, nonce, din, tin, exp_out, exp_tag;
    bit            exp_fail;
  } vec_t;
  vec_t vecs[5];

  task automatic run_small(input int idx);
    int   n;
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    s_key = v.key; s_nonce = v.nonce; s_dec = v.dec; s_tag_in = v.tin;
    s_ad_len = 8'd0; s_data_len = 8'd1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk($sformatf("v%0d_busy", idx), s_busy, 1);
    n = 0;
    while (!s_in_ready && n < 10) begin @(negedge clk); n++; end
    chk($sformatf("v%0d_ready_latency", idx), n, 1);
    s_indata = v.din; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    chk($sformatf("v%0d_out_valid", idx), s_out_valid, 1);
    chk($sformatf("v%0d_outdata", idx), s_outdata, v.exp_out);
    n = 0;
    while (!s_finish && n < 10) begin @(negedge clk); n++; end
    chk($sformatf("v%0d_finish_latency", idx), n, 2);
    chk($sformatf("v%0d_tag", idx), s_tag, v.exp_tag);
    chk($sformatf("v%0d_tag_valid", idx), s_tag_valid, 1);
    chk($sformatf("v%0d_auth_fail", idx), s_auth_fail, v.exp_fail);
    @(negedge clk);
    chk($sformatf("v%0d_finish_width", idx), {s_finish, s_busy, s_tag_valid}, 3'b001);
  endtask

  // ---------------- reference model for the big instance ----------------
  logic [W-1:0] blk[32];
  logic [W-1:0] exp_out[32];
  logic [W-1:0] got_out[32];
  logic [W-1:0] exp_tag;
  bit           exp_fail;

  function automatic logic [W-1:0] perm(input logic [W-1:0] x, input logic [W-1:0] k);
    logic [W-1:0] s;
    s = x;
    for (int i = 0; i < R; i++) s = ((s << 1) | (s >> (W - 1))) ^ k;
    return s;
  endfunction

  task automatic model_run(input logic [W-1:0] k, input logic [W-1:0] nn, input bit dec,
                           input int nad, input int nd, input logic [W-1:0] tin);
    logic [W-1:0] s, o;
    s = perm(k ^ nn, k);
    for (int i = 0; i < nad; i++) s = perm(s ^ blk[i], k);
    for (int j = 0; j < nd; j++) begin
      o = blk[nad + j] ^ s;
      exp_out[j] = o;
      s = perm(s ^ (dec ? o : blk[nad + j]), k);
    end
    exp_tag  = s ^ k;
    exp_fail = dec && (exp_tag != tin);
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one full operation with continuous upstream valid. Expected accept
  // cycles follow from the timing rules: each block needs R+1 cycles after the
  // previous accept and the previous output must have drained first.
  task automatic run_big(input string tn, input logic [W-1:0] k, input logic [W-1:0] nn,
                         input bit dec, input int nad, input int nd, input logic [W-1:0] tin,
                         input int stall_blk, input int stall_len, input bit spur,
                         input int abort_at);
    int nblk, acc_idx, out_idx, exp_acc, exp_fin, last_acc, exp_drain, finish_c;
    int stall_lo, stall_hi, j;
    bit busy_bad, ready_bad, stall_bad;
    logic [W-1:0] hold;
    nblk = nad + nd; acc_idx = 0; out_idx = 0; last_acc = 0; exp_drain = 0;
    finish_c = -1; stall_lo = -1; stall_hi = -2; hold = '0;
    busy_bad = 0; ready_bad = 0; stall_bad = 0;
    exp_acc = R + 1;
    model_run(k, nn, dec, nad, nd, tin);
    @(negedge clk);
    b_key = k; b_nonce = nn; b_dec = dec; b_tag_in = tin;
    b_ad_len = 8'(nad); b_data_len = 8'(nd); b_start = 1'b1;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (c == abort_at) begin
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tn, "_reset_flags"},
            {b_busy, b_finish, b_in_ready, b_out_valid, b_tag_valid, b_auth_fail}, 6'b0);
        chk({tn, "_reset_outdata"}, b_outdata, '0);
        chk({tn, "_reset_tag"}, b_tag, '0);
        b_out_ready = 1'b1;
        return;
      end
      b_start    = spur && (c == 2);
      b_key      = (spur && c == 2) ? ~k : k;
      b_ad_len   = (spur && c == 2) ? 8'd0 : 8'(nad);
      b_data_len = (spur && c == 2) ? 8'd0 : 8'(nd);
      b_in_valid = (acc_idx < nblk);
      b_indata   = b_in_valid ? blk[acc_idx] : rnd128();
      b_out_ready = !(c >= stall_lo && c <= stall_hi);
      #1;
      if (b_busy !== 1'b1) busy_bad = 1;
      if (b_in_ready && !b_in_valid) ready_bad = 1;
      if (c >= stall_lo && c <= stall_hi)
        if (b_out_valid !== 1'b1 || b_outdata !== hold || b_in_ready !== 1'b0) stall_bad = 1;
      if (b_in_ready && b_in_valid) begin
        chk($sformatf("%s_accept%0d_cycle", tn, acc_idx), c, exp_acc);
        exp_drain = 0;
        if (acc_idx >= nad) begin
          j = acc_idx - nad;
          exp_drain = c + 1 + ((j == stall_blk) ? stall_len : 0);
          if (j == stall_blk && stall_len > 0) begin
            stall_lo = c + 1; stall_hi = c + stall_len; hold = exp_out[j];
          end
        end
        last_acc = c;
        acc_idx++;
        exp_acc = (c + R + 1 > exp_drain + 1) ? c + R + 1 : exp_drain + 1;
      end
      if (b_out_valid && b_out_ready) begin
        if (out_idx < 32) got_out[out_idx] = b_outdata;
        if (out_idx < nd) chk($sformatf("%s_out%0d", tn, out_idx), b_outdata, exp_out[out_idx]);
        out_idx++;
      end
      if (b_finish) begin
        finish_c = c;
        break;
      end
      @(negedge clk);
    end
    exp_fin = ((last_acc + R + 1 > exp_drain + 1) ? last_acc + R + 1 : exp_drain + 1) + 1;
    chk({tn, "_finish_cycle"}, finish_c, exp_fin);
    chk({tn, "_out_count"}, out_idx, nd);
    chk({tn, "_busy_span"}, busy_bad, 0);
    chk({tn, "_no_spurious_ready"}, ready_bad, 0);
    if (stall_len > 0) chk({tn, "_stall_hold"}, stall_bad, 0);
    chk({tn, "_tag"}, b_tag, exp_tag);
    chk({tn, "_tag_valid"}, b_tag_valid, 1);
    chk({tn, "_auth_fail"}, b_auth_fail, exp_fail);
    @(negedge clk);
    #1;
    chk({tn, "_after_finish"}, {b_finish, b_busy, b_tag_valid}, 3'b001);
  endtask

  logic [W-1:0] k0, n0, pt[4], ct_tag;

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h04, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 8'h01, 8'h02, 8'h04, 8'h00, 8'h04, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'h01, 8'h02, 8'h05, 8'h00, 8'h04, 1'b1};
    vecs[3] = '{1'b0, 8'h10, 8'h81, 8'h3C, 8'hFF, 8'h0F, 8'h1E, 1'b0};
    vecs[4] = '{1'b1, 8'h10, 8'h81, 8'h0F, 8'h1E, 8'h3C, 8'h1E, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_small", {s_busy, s_finish, s_in_ready, s_out_valid, s_tag_valid,
                        s_auth_fail, s_outdata, s_tag}, '0);
    chk("reset_big_flags", {b_busy, b_finish, b_in_ready, b_out_valid, b_tag_valid,
                            b_auth_fail}, '0);
    chk("reset_big_data", b_outdata | b_tag, '0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_small(i);

    // Encrypt / decrypt round trip with AD.
    k0 = rnd128(); n0 = rnd128();
    for (int i = 0; i < 4; i++) blk[i] = rnd128();
    pt[0] = blk[2]; pt[1] = blk[3];
    run_big("enc22", k0, n0, 1'b0, 2, 2, rnd128(), -1, 0, 1'b0, 0);
    ct_tag = exp_tag;
    blk[2] = exp_out[0]; blk[3] = exp_out[1];
    run_big("dec22", k0, n0, 1'b1, 2, 2, ct_tag, -1, 0, 1'b0, 0);
    chk("roundtrip_pt0", got_out[0], pt[0]);
    chk("roundtrip_pt1", got_out[1], pt[1]);
    chk("roundtrip_tag", b_tag, ct_tag);
    run_big("dec22_badtag", k0, n0, 1'b1, 2, 2, ct_tag ^ 128'h1, -1, 0, 1'b0, 0);

    // Backpressure on the first output, then on the last output.
    for (int i = 0; i < 4; i++) blk[i] = rnd128();
    run_big("stall_first", rnd128(), rnd128(), 1'b0, 1, 3, '0, 0, 10, 1'b0, 0);
    run_big("stall_last", rnd128(), rnd128(), 1'b1, 0, 2, rnd128(), 1, 10, 1'b0, 0);

    // Empty operation.
    run_big("empty", rnd128(), rnd128(), 1'b0, 0, 0, '0, -1, 0, 1'b0, 0);

    // Reset in DATA_PERM with a full output register, then a clean rerun
    // with a start pulse while busy.
    k0 = rnd128(); n0 = rnd128();
    for (int i = 0; i < 3; i++) blk[i] = rnd128();
    run_big("abort", k0, n0, 1'b0, 1, 2, '0, 0, 10, 1'b0, 13);
    run_big("rerun", k0, n0, 1'b0, 1, 2, '0, -1, 0, 1'b1, 0);

    // Randomised operations.
    for (int it = 0; it < 6; it++) begin
      int nad, nd;
      nad = $urandom_range(0, 3);
      nd  = $urandom_range(0, 3);
      for (int i = 0; i < 6; i++) blk[i] = rnd128();
      run_big($sformatf("rand%0d", it), rnd128(), rnd128(), 1'($urandom_range(0, 1)),
              nad, nd, rnd128(), (nd > 0) ? $urandom_range(0, nd - 1) : -1,
              $urandom_range(0, 7), 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
